// File: rtl/dense_layer_seq_pkg.sv
// Shared types, sizes and fixed-point helpers for the sequential dense layer.
package dense_pkg;

    localparam int N    = 32;
    localparam int W    = 16;
    localparam int FRAC = 11;
    localparam int AW   = $clog2(W * W);
    localparam int IW   = $clog2(W);

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } seq_state_t;

    // Full-precision product, arithmetic shift per term (floor), truncated to N bits.
    function automatic logic signed [N-1:0] fx_term(input logic signed [N-1:0] w,
                                                    input logic signed [N-1:0] x,
                                                    input int frac);
        logic signed [2*N-1:0] p;
        p = $signed({{N{w[N-1]}}, w}) * $signed({{N{x[N-1]}}, x});
        p = p >>> frac;
        return p[N-1:0];
    endfunction

    function automatic logic signed [N-1:0] relu(input logic signed [N-1:0] s);
        return s[N-1] ? '0 : s;
    endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Control handshake and memory-port bundle between the layer sequencer and its buffers.
interface dense_layer_seq_if;
    import dense_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        w_addr;
    logic signed [N-1:0]  w_rdata;
    logic [IW-1:0]        x_addr;
    logic signed [N-1:0]  x_rdata;
    logic [IW-1:0]        b_addr;
    logic signed [N-1:0]  b_rdata;
    logic                 y_we;
    logic [IW-1:0]        y_addr;
    logic signed [N-1:0]  y_wdata;

    modport master (
        input  start, w_rdata, x_rdata, b_rdata,
        output busy, done, w_addr, x_addr, b_addr, y_we, y_addr, y_wdata
    );

    modport slave (
        output start, w_rdata, x_rdata, b_rdata,
        input  busy, done, w_addr, x_addr, b_addr, y_we, y_addr, y_wdata
    );

endinterface

// File: rtl/dense_layer_seq_mac.sv
// Single multiply-shift-accumulate stage; the accumulator wraps at N bits.
module mac_unit
    import dense_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] acc
);

    logic signed [N-1:0] acc_nxt;

    assign acc_nxt = acc + fx_term(a, b, FRAC);

    // Accumulator register: clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequencer for one fully connected layer: walks W/x/b memories, one MAC per cycle.
//
//  state | meaning
//  IDLE  | waiting for start; accumulator held clear
//  MAC   | issuing row i, column j addresses; accumulating column j-1
//  DRAIN | accumulating the last column's product
//  WRITE | y_we high, y[i] = relu(acc + b[i]); next row or finish
//  DONE  | one-cycle done pulse, busy low
module dense_layer_seq
    import dense_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    dense_layer_seq_if.master  bus
);

    seq_state_t          state;
    logic                mac_clr;
    logic                mac_en;
    logic signed [N-1:0] acc;
    logic signed [N-1:0] bias_sum;

    // Read data lags the address by one cycle, so column 0 of a row has nothing to add yet.
    assign mac_clr  = (state == IDLE) || (state == WRITE);
    assign mac_en   = ((state == MAC) && (bus.x_addr != '0)) || (state == DRAIN);
    assign bias_sum = acc + bus.b_rdata;

    // Write data is held at zero outside the write strobe so the output bus stays quiet.
    assign bus.y_wdata = bus.y_we ? relu(bias_sum) : '0;

    mac_unit u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (bus.w_rdata),
        .b   (bus.x_rdata),
        .acc (acc)
    );

    // Sequencer: x_addr doubles as the column counter and b_addr as the row counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.y_we   <= 1'b0;
            bus.w_addr <= '0;
            bus.x_addr <= '0;
            bus.b_addr <= '0;
            bus.y_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state      <= MAC;
                        bus.busy   <= 1'b1;
                        bus.w_addr <= '0;
                        bus.x_addr <= '0;
                        bus.b_addr <= '0;
                    end
                end
                MAC: begin
                    if (bus.x_addr == IW'(W - 1)) begin
                        state <= DRAIN;
                    end else begin
                        bus.x_addr <= bus.x_addr + IW'(1);
                        bus.w_addr <= bus.w_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    state      <= WRITE;
                    bus.y_we   <= 1'b1;
                    bus.y_addr <= bus.b_addr;
                end
                WRITE: begin
                    bus.y_we <= 1'b0;
                    if (bus.b_addr == IW'(W - 1)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        // Weight address is row-major, so the next row simply continues the count.
                        state      <= MAC;
                        bus.b_addr <= bus.b_addr + IW'(1);
                        bus.x_addr <= '0;
                        bus.w_addr <= bus.w_addr + AW'(1);
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Scoreboard bench for dense_layer_seq: directed passes, start abuse, mid-pass reset.
module tb_dense_layer_seq;
    import dense_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dense_layer_seq_if bus();

    dense_layer_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic signed [N-1:0] wmem [W*W];
    logic signed [N-1:0] xmem [W];
    logic signed [N-1:0] bmem [W];

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk) begin
        bus.w_rdata <= wmem[bus.w_addr];
        bus.x_rdata <= xmem[bus.x_addr];
        bus.b_rdata <= bmem[bus.b_addr];
    end

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t expq[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    int done_cnt = 0;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write strobe is popped against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.y_we === 1'b1) begin
            we_cnt++;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL y_unexpected got addr=%0d data=%0d expected no write",
                         bus.y_addr, bus.y_wdata);
            end else begin
                e = expq.pop_front();
                if (int'(bus.y_addr) !== e.addr || bus.y_wdata !== e.data) begin
                    errors++;
                    $display("FAIL y_write got addr=%0d data=%0d expected addr=%0d data=%0d",
                             bus.y_addr, bus.y_wdata, e.addr, e.data);
                end
            end
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Fill memories for a scenario and queue the hand-computed outputs for each pass.
    task automatic load(input int scn, input int passes);
        int wv, xv, bv, yv;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                case (scn)
                    1: begin wv = (i == j) ? 2048 : 0; xv = j * 2048; bv = 0;   yv = i * 2048; end
                    2: begin wv = 2048;                xv = -2048;    bv = 100; yv = 0;        end
                    3: begin wv = -1;                  xv = 1;        bv = 20;  yv = 4;        end
                    default: begin wv = 1;             xv = 1;        bv = 5;   yv = 5;        end
                endcase
                wmem[i*W + j] = wv;
                xmem[j]       = xv;
                bmem[i]       = bv;
            end
        end
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < W; i++) begin
                case (scn)
                    1:       expq.push_back('{i, i * 2048});
                    2:       expq.push_back('{i, 0});
                    3:       expq.push_back('{i, 4});
                    default: expq.push_back('{i, 5});
                endcase
            end
        end
    endtask

    // One pass; optional extra start pulses at relative cycles pa/pb (0 = none).
    task automatic run_pass(input string tag, input int pa, input int pb);
        int  s, we0, d0, busy_low;
        bit  seen;
        we0      = we_cnt;
        d0       = done_cnt;
        busy_low = 0;
        seen     = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        s = cyc;
        for (int n = 1; n <= 400 && !seen; n++) begin
            @(negedge clk);
            bus.start = (n == pa) || (n == pb);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                chk({tag, "_done_latency"}, cyc - s, 289);
                chk({tag, "_busy_at_done"}, bus.busy, 0);
            end else if (bus.busy !== 1'b1) begin
                busy_low++;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_gap"}, busy_low, 0);
        @(negedge clk);
        chk({tag, "_we_count"}, we_cnt - we0, 16);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_queue_left"}, expq.size(), 0);
    endtask

    initial begin
        int s, d1, d2, we0, d0;
        bus.start = 1'b0;
        load(1, 0);

        // Reset state.
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",    bus.busy,    0);
        chk("rst_done",    bus.done,    0);
        chk("rst_y_we",    bus.y_we,    0);
        chk("rst_w_addr",  bus.w_addr,  0);
        chk("rst_x_addr",  bus.x_addr,  0);
        chk("rst_b_addr",  bus.b_addr,  0);
        chk("rst_y_addr",  bus.y_addr,  0);
        chk("rst_y_wdata", bus.y_wdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed value scenarios.
        load(1, 1); run_pass("identity", 0, 0);
        load(2, 1); run_pass("relu_clamp", 0, 0);
        load(3, 1); run_pass("neg_term", 0, 0);
        load(4, 1); run_pass("small_term", 0, 0);

        // start during a pass must be ignored.
        load(1, 1); run_pass("start_ignored", 50, 120);

        // Reset mid-pass: outputs drop immediately, no done, then a clean pass.
        load(1, 1);
        we0 = we_cnt;
        d0  = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (98) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_y_we", bus.y_we, 0);
        chk("abort_done", bus.done, 0);
        expq.delete();
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_partial_writes", we_cnt - we0, 5);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        load(1, 1); run_pass("after_abort", 0, 0);

        // start held high: back-to-back passes, one IDLE cycle between them.
        load(1, 2);
        we0 = we_cnt;
        d1  = -1;
        d2  = -1;
        @(negedge clk);
        bus.start = 1'b1;
        s = cyc;
        for (int n = 1; n <= 700 && d2 < 0; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc;
                end else begin
                    d2 = cyc;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        chk("hold_second_done_seen", d2 >= 0, 1);
        chk("hold_first_done", d1 - s, 289);
        chk("hold_period", d2 - d1, 290);
        repeat (3) @(negedge clk);
        chk("hold_we_count", we_cnt - we0, 32);
        chk("hold_queue_left", expq.size(), 0);
        chk("hold_idle_after", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
